// File: rtl/cnn_bias_pkg.sv
// Shared constants and FSM state type for the CNN bias memory loader.
package cnn_bias_pkg;

    localparam int unsigned BIAS_NUM = 10;
    localparam int unsigned DATA_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } bias_ld_state_t;

endpackage

// File: rtl/bias_load_ctrl.sv
// Loads bias words from external memory into the bias memory, then serves PE bias lookups.
// Optional sticky over-count flag `err` is enabled with `define BIAS_LOAD_ERR_EN.
module bias_load_ctrl #(
    parameter int unsigned BIAS_NUM = cnn_bias_pkg::BIAS_NUM,
    parameter int unsigned DATA_W   = cnn_bias_pkg::DATA_W,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       bias_cnt,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              write_bias_signal,
    output logic [15:0]       write_bias_addr,
    output logic [DATA_W-1:0] write_bias_data,
    input  logic              ch_req,
    input  logic [15:0]       ch_idx,
    output logic              read_bias_signal,
    output logic [15:0]       read_bias_addr,
    input  logic [DATA_W-1:0] read_bias_data,
    output logic [DATA_W-1:0] bias_out,
    output logic              bias_valid
`ifdef BIAS_LOAD_ERR_EN
    ,
    output logic              err
`endif
);

    import cnn_bias_pkg::*;

    localparam logic [15:0] MAX_CNT = 16'(BIAS_NUM);

    bias_ld_state_t    state_q, state_d;
    logic [15:0]       idx_q, idx_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] bias_out_q;
    logic              bias_valid_q;
    logic              cnt_over;
    logic [15:0]       cnt_clamped;

    assign cnt_over    = (bias_cnt > MAX_CNT);
    assign cnt_clamped = cnt_over ? MAX_CNT : bias_cnt;

`ifdef BIAS_LOAD_ERR_EN
    logic err_q, err_d;
    assign err = err_q;
`endif

    // State and load datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            rdata_q <= '0;
`ifdef BIAS_LOAD_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            rdata_q <= rdata_d;
`ifdef BIAS_LOAD_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        rdata_d = rdata_q;
`ifdef BIAS_LOAD_ERR_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    cnt_d   = cnt_clamped;
                    idx_d   = '0;
`ifdef BIAS_LOAD_ERR_EN
                    err_d   = cnt_over;
`endif
                    state_d = (cnt_clamped == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                idx_d   = idx_q + 16'd1;
                state_d = (idx_d == cnt_q) ? ST_DONE : ST_REQ;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus and write-port outputs are zero outside their owning state
    always_comb begin
        busy              = (state_q != ST_IDLE);
        done              = (state_q == ST_DONE);
        mem_req           = 1'b0;
        mem_addr          = '0;
        write_bias_signal = 1'b0;
        write_bias_addr   = '0;
        write_bias_data   = '0;
        case (state_q)
            ST_REQ: begin
                mem_req  = 1'b1;
                mem_addr = base_q + ADDR_W'({idx_q, 1'b0});
            end
            ST_WRITE: begin
                write_bias_signal = 1'b1;
                write_bias_addr   = idx_q;
                write_bias_data   = rdata_q;
            end
            default: ;
        endcase
    end

    // PE read path: lookups are dropped while a load is in progress
    assign read_bias_signal = ch_req & ~busy;
    assign read_bias_addr   = ch_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            bias_valid_q <= 1'b0;
            bias_out_q   <= '0;
        end else begin
            bias_valid_q <= read_bias_signal;
            if (read_bias_signal) bias_out_q <= read_bias_data;
        end
    end

    assign bias_out   = bias_out_q;
    assign bias_valid = bias_valid_q;

endmodule

// File: tb/tb_bias_load_ctrl.sv
// Directed testbench for bias_load_ctrl with a behavioural bias memory.
module tb_bias_load_ctrl;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] base_addr;
    logic [15:0] bias_cnt;
    logic        busy, done, mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt, mem_rvalid;
    logic [15:0] mem_rdata;
    logic        write_bias_signal;
    logic [15:0] write_bias_addr, write_bias_data;
    logic        ch_req;
    logic [15:0] ch_idx;
    logic        read_bias_signal;
    logic [15:0] read_bias_addr, read_bias_data;
    logic [15:0] bias_out;
    logic        bias_valid;
`ifdef BIAS_LOAD_ERR_EN
    logic        err;
`endif

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [15:0] bmem [0:9];

    always #5 clk = ~clk;

    bias_load_ctrl #(.BIAS_NUM(10), .DATA_W(16), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .bias_cnt(bias_cnt),
        .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .write_bias_signal(write_bias_signal), .write_bias_addr(write_bias_addr),
        .write_bias_data(write_bias_data), .ch_req(ch_req), .ch_idx(ch_idx),
        .read_bias_signal(read_bias_signal), .read_bias_addr(read_bias_addr),
        .read_bias_data(read_bias_data), .bias_out(bias_out), .bias_valid(bias_valid)
`ifdef BIAS_LOAD_ERR_EN
        , .err(err)
`endif
    );

    // Bias memory model: out-of-range reads return zero
    always @(posedge clk) begin
        if (write_bias_signal) begin
            wr_cnt <= wr_cnt + 1;
            if (write_bias_addr < 16'd10) bmem[write_bias_addr[3:0]] <= write_bias_data;
        end
        if (done) done_cnt <= done_cnt + 1;
    end
    assign read_bias_data = (read_bias_addr < 16'd10) ? bmem[read_bias_addr[3:0]] : 16'h0000;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    task automatic start_load(input logic [31:0] base, input logic [15:0] cnt);
        start = 1'b1; base_addr = base; bias_cnt = cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_one(input int i, input logic [31:0] base, input int gnt_dly,
                            input int rv_dly, input logic [15:0] d, input bit chk_lat);
        int n = 0;
        logic [31:0] ea;
        ea = base + 32'(2 * i);
        while (mem_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if (mem_req !== 1'b1 || (chk_lat && n != 0)) begin
            miscompares++;
            $display("FAIL req_wait[%0d]: mem_req=%b after %0d cycles, required 1 after %0d", i, mem_req, n, 0);
        end
        vectors++;
        if (mem_addr !== ea) begin
            miscompares++;
            $display("FAIL req_addr[%0d]: got %h required %h", i, mem_addr, ea);
        end
        repeat (gnt_dly) begin
            @(negedge clk);
            vectors++;
            if (mem_req !== 1'b1 || mem_addr !== ea) begin
                miscompares++;
                $display("FAIL req_stable[%0d]: req=%b addr=%h required 1/%h", i, mem_req, mem_addr, ea);
            end
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL req_drop[%0d]: got %b required 0", i, mem_req);
        end
        repeat (rv_dly) begin
            @(negedge clk);
            vectors++;
            if (write_bias_signal !== 1'b0 || mem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL wait_idle[%0d]: wr=%b req=%b required 0/0", i, write_bias_signal, mem_req);
            end
        end
        mem_rvalid = 1'b1; mem_rdata = d;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 16'h0;
        vectors++;
        if (write_bias_signal !== 1'b1 || write_bias_addr !== 16'(i) || write_bias_data !== d) begin
            miscompares++;
            $display("FAIL write[%0d]: sig=%b addr=%0d data=%h required 1/%0d/%h",
                     i, write_bias_signal, write_bias_addr, write_bias_data, i, d);
        end
        @(negedge clk);
    endtask

    task automatic check_done(input string name);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_done: done=%b busy=%b required 1/1", name, done, busy);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle: done=%b busy=%b required 0/0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; bias_cnt = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; ch_req = 1'b0; ch_idx = '0;
        for (int k = 0; k < 10; k++) bmem[k] = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy, done, mem_req, write_bias_signal, bias_valid} !== 5'b0 || bias_out !== 16'h0
            || write_bias_data !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy/done/req/wr/valid=%b%b%b%b%b out=%h wdata=%h required 0",
                     busy, done, mem_req, write_bias_signal, bias_valid, bias_out, write_bias_data);
        end
    endtask

    task automatic test_load3();
        int w0, d0;
        logic [15:0] data [3];
        data = '{16'h0011, 16'h0022, 16'h0033};
        w0 = wr_cnt; d0 = done_cnt;
        start_load(32'h1000, 16'd3);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL load3_busy: got %b required 1", busy);
        end
        for (int i = 0; i < 3; i++) load_one(i, 32'h1000, 0, 0, data[i], 1'b1);
        check_done("load3");
        vectors++;
        if (wr_cnt - w0 != 3 || done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL load3_counts: writes=%0d dones=%0d required 3/1", wr_cnt - w0, done_cnt - d0);
        end
    endtask

    task automatic test_read();
        ch_req = 1'b1; ch_idx = 16'd2;
        #1;
        vectors++;
        if (read_bias_signal !== 1'b1 || read_bias_addr !== 16'd2) begin
            miscompares++;
            $display("FAIL read_comb: sig=%b addr=%0d required 1/2", read_bias_signal, read_bias_addr);
        end
        @(negedge clk);
        vectors++;
        if (bias_valid !== 1'b1 || bias_out !== 16'h0033) begin
            miscompares++;
            $display("FAIL read_idx2: valid=%b out=%h required 1/0033", bias_valid, bias_out);
        end
        ch_idx = 16'd0;
        @(negedge clk);
        vectors++;
        if (bias_valid !== 1'b1 || bias_out !== 16'h0011) begin
            miscompares++;
            $display("FAIL read_idx0: valid=%b out=%h required 1/0011", bias_valid, bias_out);
        end
        ch_idx = 16'd12;
        @(negedge clk);
        vectors++;
        if (bias_valid !== 1'b1 || bias_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL read_oor: valid=%b out=%h required 1/0000", bias_valid, bias_out);
        end
        ch_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (bias_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL read_stop: valid=%b required 0", bias_valid);
        end
    endtask

    task automatic test_cnt_zero();
        int w0;
        w0 = wr_cnt;
        start_load(32'h5000, 16'd0);
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL cnt0_req: got %b required 0", mem_req);
        end
        check_done("cnt0");
        vectors++;
        if (wr_cnt != w0) begin
            miscompares++;
            $display("FAIL cnt0_writes: got %0d required 0", wr_cnt - w0);
        end
    endtask

    task automatic test_clamp_and_busy_read();
        int w0;
        w0 = wr_cnt;
        start_load(32'h2000, 16'd12);
        ch_req = 1'b1; ch_idx = 16'd1;
        #1;
        vectors++;
        if (read_bias_signal !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_read_sig: got %b required 0", read_bias_signal);
        end
        @(negedge clk);
        ch_req = 1'b0;
        vectors++;
        if (bias_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_read_valid: got %b required 0", bias_valid);
        end
        for (int i = 0; i < 10; i++) load_one(i, 32'h2000, 0, 0, 16'h0100 + 16'(i), 1'b0);
        check_done("cnt12");
        vectors++;
        if (wr_cnt - w0 != 10) begin
            miscompares++;
            $display("FAIL cnt12_writes: got %0d required 10", wr_cnt - w0);
        end
`ifdef BIAS_LOAD_ERR_EN
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL cnt12_err: got %b required 1", err);
        end
`endif
    endtask

    task automatic test_delayed_handshake();
        int w0;
        w0 = wr_cnt;
        start_load(32'h3000, 16'd2);
        load_one(0, 32'h3000, 4, 3, 16'hA5A5, 1'b0);
        start_load(32'h9000, 16'd5);
        load_one(1, 32'h3000, 4, 3, 16'h5A5A, 1'b0);
        check_done("delayed");
        vectors++;
        if (wr_cnt - w0 != 2) begin
            miscompares++;
            $display("FAIL delayed_writes: got %0d required 2", wr_cnt - w0);
        end
`ifdef BIAS_LOAD_ERR_EN
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL delayed_err_clear: got %b required 0", err);
        end
`endif
    endtask

    task automatic test_reset_midload();
        int w0;
        w0 = wr_cnt;
        start_load(32'h4000, 16'd2);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy, done, mem_req, write_bias_signal} !== 4'b0 || write_bias_data !== 16'h0) begin
            miscompares++;
            $display("FAIL midrst_outputs: busy/done/req/wr=%b%b%b%b wdata=%h required 0",
                     busy, done, mem_req, write_bias_signal, write_bias_data);
        end
        mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_rvalid = 1'b0;
        vectors++;
        if (write_bias_signal !== 1'b0 || busy !== 1'b0 || wr_cnt != w0) begin
            miscompares++;
            $display("FAIL midrst_late_rvalid: wr=%b busy=%b writes=%0d required 0/0/0",
                     write_bias_signal, busy, wr_cnt - w0);
        end
    endtask

    initial begin
        test_reset();
        test_load3();
        test_read();
        test_cnt_zero();
        test_clamp_and_busy_read();
        test_delayed_handshake();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bias_load_ctrl.md
Name: bias_load_ctrl

Overview:
Sequencer for the CNN bias local memory (10 x 16-bit entries).
- On `start`, fetches `bias_cnt` bias words from external memory over a req/gnt/rvalid handshake and writes each into the bias memory's write port.
- Afterwards, serves per-channel bias lookups to the PE array through the bias memory's read port.
- Sits between the CNN top-level controller / bus master and the bias memory.

Parameters:
- BIAS_NUM, 10, bias memory depth; maximum loadable entries.
- DATA_W, 16, bias word width.
- ADDR_W, 32, external memory byte-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle load command; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of bias 0 in external memory.
- bias_cnt  in  16  number of biases to load.
- busy  out  1  high from the cycle after `start` is accepted until DONE.
- done  out  1  one-cycle pulse at load completion.
- mem_req  out  1  external read request.
- mem_addr  out  ADDR_W  external read address.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.
- write_bias_signal  out  1  bias memory write enable.
- write_bias_addr  out  16  bias memory write index.
- write_bias_data  out  DATA_W  bias memory write data.
- ch_req  in  1  PE request for one channel's bias.
- ch_idx  in  16  requested channel index.
- read_bias_signal  out  1  bias memory read enable (combinational).
- read_bias_addr  out  16  bias memory read index (combinational).
- read_bias_data  in  DATA_W  bias memory read data (combinational).
- bias_out  out  DATA_W  registered bias for the PE.
- bias_valid  out  1  one-cycle pulse; `bias_out` valid.

Behaviour:
- **Reset:** all registered outputs 0; FSM in IDLE; `idx`=0, `cnt`=0.
- **FSM states:** IDLE, REQ, WAIT, WRITE, DONE.
- **IDLE:**
  - `start`=1 latches `base_addr` and `cnt`=min(`bias_cnt`, BIAS_NUM).
  - If `cnt`==0, go to DONE; otherwise go to REQ with `idx`=0.
- **REQ:**
  - `mem_req`=1 and `mem_addr`=base+2*`idx`, held stable until `mem_gnt` is sampled high.
  - On `mem_gnt`, go to WAIT; `mem_req` drops next cycle.
  - `mem_gnt` may arrive in the first REQ cycle.
- **WAIT:**
  - On `mem_rvalid`, capture `mem_rdata` and go to WRITE.
  - No timeout; exactly one request is outstanding at a time.
- **WRITE:**
  - `write_bias_signal`=1 for one cycle, with `write_bias_addr`=`idx` and `write_bias_data`=captured word.
  - Then `idx`++. If `idx`==`cnt`, go to DONE; otherwise go to REQ.
- **DONE:** `done`=1 for one cycle, then IDLE. `busy`=1 in REQ/WAIT/WRITE/DONE.
- **Latency per bias:** REQ→WRITE takes 3 cycles minimum (gnt and rvalid each arriving on their first eligible cycle).
- **Read path (outside busy):**
  - `read_bias_signal`=`ch_req`, `read_bias_addr`=`ch_idx`, both combinational.
  - Next cycle: `bias_out`=`read_bias_data` and `bias_valid`=1.
  - Back-to-back requests give one result per cycle.
- **Read path (during busy):** `read_bias_signal`=0; `ch_req` is dropped, with no `bias_valid`.
- `ch_idx` ≥ BIAS_NUM is passed through unchanged; the bias memory returns 0.
- `start` outside IDLE is ignored.
- `mem_rvalid` outside WAIT is ignored.
- `rst` mid-load returns to IDLE next edge, with `mem_req`/`write_bias_signal` low. Already-written entries are not cleared by this block.

Optional Feature:
- Macro: BIAS_LOAD_ERR_EN.
- **Defined:** adds output `err` (1 bit, sticky).
  - Set on accepted `start` with `bias_cnt` > BIAS_NUM.
  - Cleared on the next accepted `start` with a legal count, or on `rst`.
  - Clamping still applies.
- **Undefined:** no `err` port; silent clamp.

Decomposition:
- Package `cnn_bias_pkg`:
  - BIAS_NUM and DATA_W constants.
  - FSM state enum `bias_ld_state_t`.
- No sub-module; a single module is natural. The read path is a small always_ff plus combinational assignments within it.

Test Plan:
- **Load 3 biases:** `start`, base=0x1000, cnt=3, mem returns 0x0011/0x0022/0x0033.
  - Required: `mem_addr` 0x1000/0x1002/0x1004.
  - Required: writes idx 0/1/2 with the matching data.
  - Required: single `done` pulse; `busy` falls the cycle after `done`.
- **cnt=0:** `done` the cycle after `start`; no `mem_req`, no writes.
- **cnt=12:** exactly 10 writes (idx 0..9), then `done`; `err`=1 when BIAS_LOAD_ERR_EN is defined.
- **Delayed handshake:** gnt delayed 4 cycles and rvalid 3 cycles; `mem_req`/`mem_addr` stay stable through the gnt delay; a second `start` mid-load is ignored.
- **Post-load read:** `ch_req` at idx 2 then idx 0 on back-to-back cycles.
  - Required: `bias_valid` on 2 consecutive cycles, `bias_out`=0x0033 then 0x0011.
  - A `ch_req` during `busy` yields no `bias_valid`.
- **Reset mid-load:** `rst` in WAIT; next cycle IDLE with outputs 0; a late `mem_rvalid` causes no write.
